// File: rtl/alu_exec_unit_if.sv
// Handshake bus for the ALU execution unit: op/operand request side and result/flags response side.
`timescale 1ns/1ps
interface alu_exec_unit_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   alu_op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [4:0]   flags;
  logic         illegal;

  modport master (output in_valid, alu_op, a, b, out_ready,
                  input  in_ready, out_valid, result, flags, illegal);
  modport slave  (input  in_valid, alu_op, a, b, out_ready,
                  output in_ready, out_valid, result, flags, illegal);
endinterface

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith ops, bit-serial shifts, shift-add MUL, status flags.
`timescale 1ns/1ps
module alu_exec_unit #(
  parameter int W       = 16,
  parameter int SHAMT_W = 5
) (
  input  logic        clock,
  input  logic        reset,
  alu_exec_unit_if.slave bus
);
  localparam logic [7:0] OP_AND  = 8'h01, OP_OR   = 8'h02, OP_XOR  = 8'h03, OP_ADD  = 8'h05,
                         OP_ADDU = 8'h06, OP_ADDC = 8'h07, OP_SUB  = 8'h09, OP_SUBC = 8'h0A,
                         OP_CMP  = 8'h0B, OP_MOV  = 8'h0D, OP_MUL  = 8'h0E, OP_LSH  = 8'h84,
                         OP_ASHU = 8'h86, OP_LINK = 8'h4F, OP_LUI  = 8'hF0;
  localparam int FN = 4, FZ = 3, FF = 2, FL = 1, FC = 0;
  localparam int CNT_W = (SHAMT_W > $clog2(W+1)) ? SHAMT_W : $clog2(W+1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t state, state_nx;

  logic [W-1:0]     res_q, mcand_q, mplier_q;
  logic [4:0]       flg_q;
  logic             ill_q, mul_q, left_q, arith_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_ready, out_valid, accept;

  assign accept = bus.in_valid && (state == IDLE);

  // Decode of the incoming request; only meaningful while IDLE.
  logic [7:0]         op;
  logic [SHAMT_W-1:0] amt, mag;
  logic               is_mul, is_shift, go_exec, is_sub, ci, ovf;
  logic [W:0]         ci_ext, sum_u, sum_s;
  logic [W-1:0]       res_c;
  logic [4:0]         flg_c;
  logic               ill_c;

  assign op       = bus.alu_op;
  assign amt      = bus.b[SHAMT_W-1:0];
  assign mag      = amt[SHAMT_W-1] ? (~amt + SHAMT_W'(1)) : amt;
  assign is_mul   = (op == OP_MUL);
  assign is_shift = (op == OP_LSH) || (op == OP_ASHU);
  assign go_exec  = is_mul || (is_shift && (mag != '0));
  assign is_sub   = (op == OP_SUB) || (op == OP_SUBC);
  assign ci       = ((op == OP_ADDC) || (op == OP_SUBC)) && flg_q[FC];
  assign ci_ext   = {{W{1'b0}}, ci};

  // Unsigned view gives carry/borrow in bit W; sign-extended view gives overflow as bit W != bit W-1.
  assign sum_u = is_sub ? ({1'b0, bus.a} - {1'b0, bus.b} - ci_ext)
                        : ({1'b0, bus.a} + {1'b0, bus.b} + ci_ext);
  assign sum_s = is_sub ? ({bus.a[W-1], bus.a} - {bus.b[W-1], bus.b} - ci_ext)
                        : ({bus.a[W-1], bus.a} + {bus.b[W-1], bus.b} + ci_ext);
  assign ovf   = sum_s[W] ^ sum_s[W-1];

  always_comb begin
    res_c = '0;
    flg_c = flg_q;
    ill_c = 1'b0;
    case (op)
      OP_AND:  res_c = bus.a & bus.b;
      OP_OR:   res_c = bus.a | bus.b;
      OP_XOR:  res_c = bus.a ^ bus.b;
      OP_MOV:  res_c = bus.b;
      OP_ADDU: res_c = sum_u[W-1:0];
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
        res_c     = sum_u[W-1:0];
        flg_c[FC] = sum_u[W];
        flg_c[FF] = ovf;
      end
      OP_CMP: begin
        res_c     = bus.a;
        flg_c[FZ] = (bus.a == bus.b);
        flg_c[FL] = (bus.a < bus.b);
        flg_c[FN] = ($signed(bus.a) < $signed(bus.b));
      end
      OP_MUL:  res_c = '0;
      OP_LSH, OP_ASHU: res_c = bus.a;
      OP_LINK: res_c = bus.a + W'(1);
      OP_LUI:  res_c = W'(bus.b[7:0]) << (W-8);
      default: ill_c = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nx = go_exec ? EXEC : DONE;
      end
      EXEC: if (cnt_q == CNT_W'(1)) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // res_q doubles as the shift register / product accumulator while in EXEC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_q    <= '0;
      flg_q    <= '0;
      ill_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      mul_q    <= 1'b0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          res_q    <= res_c;
          flg_q    <= flg_c;
          ill_q    <= ill_c;
          mcand_q  <= bus.a;
          mplier_q <= bus.b;
          cnt_q    <= is_mul ? CNT_W'(W) : CNT_W'(mag);
          mul_q    <= is_mul;
          left_q   <= ~amt[SHAMT_W-1];
          arith_q  <= (op == OP_ASHU);
        end
        EXEC: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (mul_q) begin
            if (mplier_q[0]) res_q <= res_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
          end else if (left_q) begin
            res_q <= res_q << 1;
          end else begin
            res_q <= {arith_q & res_q[W-1], res_q[W-1:1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = res_q;
  assign bus.flags     = flg_q;
  assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, random ops vs. arithmetic model, stall/reset corners.
`timescale 1ns/1ps
module tb_alu_exec_unit;
  localparam int W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_exec_unit_if #(.W(W)) bus();
  alu_exec_unit #(.W(W), .SHAMT_W(5)) dut (.clock(clock), .reset(reset), .bus(bus.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [15:0] a, b, res;
    logic [4:0]  flg;
    bit          ill;
    int          lat;
  } vec_t;

  function automatic vec_t mk(logic [7:0] op, logic [15:0] a, logic [15:0] b, logic [15:0] res,
                              logic [4:0] flg, bit ill, int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.flg = flg; v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // Reference: flags {N,Z,F,L,C}; computed with integer arithmetic on the opcode rules.
  function automatic void model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [4:0] fi, output logic [15:0] r, output logic [4:0] fo,
                                output bit ill, output int lat);
    int ua, ub, sa, sb, cc, s, ss, amt, mag;
    longint p;
    logic signed [15:0] t;
    ua = int'(a); ub = int'(b); sa = int'($signed(a)); sb = int'($signed(b));
    amt = int'($signed(b[4:0]));
    mag = (amt < 0) ? -amt : amt;
    r = '0; fo = fi; ill = 0; lat = 1;
    case (op)
      8'h01: r = a & b;
      8'h02: r = a | b;
      8'h03: r = a ^ b;
      8'h0D: r = b;
      8'h05, 8'h06, 8'h07: begin
        cc = (op == 8'h07) ? int'(fi[0]) : 0;
        s = ua + ub + cc; ss = sa + sb + cc; r = 16'(s);
        if (op != 8'h06) begin
          fo[0] = (s > 65535);
          fo[2] = (ss > 32767) || (ss < -32768);
        end
      end
      8'h09, 8'h0A: begin
        cc = (op == 8'h0A) ? int'(fi[0]) : 0;
        s = ua - ub - cc; ss = sa - sb - cc; r = 16'(s);
        fo[0] = (ua < ub + cc);
        fo[2] = (ss > 32767) || (ss < -32768);
      end
      8'h0B: begin r = a; fo[3] = (a == b); fo[1] = (ua < ub); fo[4] = (sa < sb); end
      8'h0E: begin p = longint'(ua) * longint'(ub); r = 16'(p); lat = W + 1; end
      8'h84: begin
        if (amt >= 0) r = a << amt; else r = a >> mag;
        lat = mag + 1;
      end
      8'h86: begin
        t = a;
        if (amt >= 0) r = a << amt; else r = t >>> mag;
        lat = mag + 1;
      end
      8'h4F: r = a + 16'd1;
      8'hF0: r = {b[7:0], 8'h00};
      default: ill = 1;
    endcase
  endfunction

  // One full transaction; hs_ok = in_ready high at issue and low until the result appears.
  task automatic xact(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                      output logic [15:0] r, output logic [4:0] f, output bit ill,
                      output int lat, output bit hs_ok);
    @(negedge clock);
    hs_ok = (bus.in_ready === 1'b1);
    bus.in_valid = 1'b1; bus.alu_op = op; bus.a = a; bus.b = b;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (bus.in_ready !== 1'b0) hs_ok = 0;
      @(negedge clock);
      lat++;
    end
    r = bus.result; f = bus.flags; ill = bus.illegal;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.out_ready = 1'b0;
  endtask

  vec_t tbl[$];
  logic [7:0] ops [16] = '{8'h01, 8'h02, 8'h03, 8'h0D, 8'h05, 8'h06, 8'h07, 8'h09,
                           8'h0A, 8'h0B, 8'h0E, 8'h84, 8'h86, 8'h4F, 8'hF0, 8'h86};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] r, er, hold_r;
    logic [4:0]  f, ef, mflags;
    logic [7:0]  op;
    logic [15:0] ra, rb;
    bit          ill, eill, hs, stable;
    int          lat, elat;

    bus.in_valid = 0; bus.alu_op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 0;

    // flags {N,Z,F,L,C}; rows chain through the carry/flag state of the previous row
    tbl.push_back(mk(8'h05, 16'h7FFF, 16'h0001, 16'h8000, 5'b00100, 0, 1));
    tbl.push_back(mk(8'h05, 16'hFFFF, 16'h0001, 16'h0000, 5'b00001, 0, 1));
    tbl.push_back(mk(8'h07, 16'h0001, 16'h0001, 16'h0003, 5'b00000, 0, 1));
    tbl.push_back(mk(8'h06, 16'h1234, 16'h1111, 16'h2345, 5'b00000, 0, 1));
    tbl.push_back(mk(8'h84, 16'h8001, 16'h001D, 16'h1000, 5'b00000, 0, 4));
    tbl.push_back(mk(8'h86, 16'h8000, 16'h001D, 16'hF000, 5'b00000, 0, 4));
    tbl.push_back(mk(8'h0E, 16'h0012, 16'h0034, 16'h03A8, 5'b00000, 0, 17));
    tbl.push_back(mk(8'h0B, 16'hFFFF, 16'h0001, 16'hFFFF, 5'b10000, 0, 1));
    tbl.push_back(mk(8'h0F, 16'h0001, 16'h0002, 16'h0000, 5'b10000, 1, 1));
    tbl.push_back(mk(8'h09, 16'h0000, 16'h0001, 16'hFFFF, 5'b10001, 0, 1));
    tbl.push_back(mk(8'h0A, 16'h8000, 16'h0001, 16'h7FFE, 5'b10100, 0, 1));
    tbl.push_back(mk(8'h0B, 16'h0005, 16'h0005, 16'h0005, 5'b01100, 0, 1));
    tbl.push_back(mk(8'h4F, 16'hFFFF, 16'h1234, 16'h0000, 5'b01100, 0, 1));
    tbl.push_back(mk(8'hF0, 16'h5555, 16'h12AB, 16'hAB00, 5'b01100, 0, 1));
    tbl.push_back(mk(8'h0D, 16'h5555, 16'h1234, 16'h1234, 5'b01100, 0, 1));
    tbl.push_back(mk(8'h01, 16'hF0F0, 16'h3C3C, 16'h3030, 5'b01100, 0, 1));
    tbl.push_back(mk(8'h02, 16'hF0F0, 16'h3C3C, 16'hFCFC, 5'b01100, 0, 1));
    tbl.push_back(mk(8'h03, 16'hF0F0, 16'h3C3C, 16'hCCCC, 5'b01100, 0, 1));
    tbl.push_back(mk(8'h84, 16'h0001, 16'h0004, 16'h0010, 5'b01100, 0, 5));
    tbl.push_back(mk(8'h86, 16'h8000, 16'h0010, 16'hFFFF, 5'b01100, 0, 17));
    tbl.push_back(mk(8'h84, 16'h8000, 16'h0010, 16'h0000, 5'b01100, 0, 17));
    tbl.push_back(mk(8'h84, 16'hABCD, 16'h0020, 16'hABCD, 5'b01100, 0, 1));
    tbl.push_back(mk(8'h86, 16'h0003, 16'h000F, 16'h8000, 5'b01100, 0, 16));
    tbl.push_back(mk(8'h86, 16'h4000, 16'h0011, 16'h0000, 5'b01100, 0, 16));
    tbl.push_back(mk(8'h0B, 16'h0001, 16'hFFFF, 16'h0001, 5'b00110, 0, 1));
    tbl.push_back(mk(8'h05, 16'h8000, 16'h8000, 16'h0000, 5'b00111, 0, 1));
    tbl.push_back(mk(8'h0A, 16'h0005, 16'h0004, 16'h0000, 5'b00010, 0, 1));
    tbl.push_back(mk(8'h07, 16'h0000, 16'h0000, 16'h0000, 5'b00010, 0, 1));

    // reset state, checked while reset is held
    repeat (3) @(negedge clock);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst result",    32'(bus.result),    32'd0);
    chk("rst flags",     32'(bus.flags),     32'd0);
    chk("rst illegal",   32'(bus.illegal),   32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst in_ready",  32'(bus.in_ready),  32'd1);

    foreach (tbl[i]) begin
      xact(tbl[i].op, tbl[i].a, tbl[i].b, r, f, ill, lat, hs);
      chk($sformatf("vec%0d result", i),  32'(r),   32'(tbl[i].res));
      chk($sformatf("vec%0d flags", i),   32'(f),   32'(tbl[i].flg));
      chk($sformatf("vec%0d illegal", i), 32'(ill), 32'(tbl[i].ill));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("vec%0d handshake", i), 32'(hs), 32'd1);
    end
    mflags = tbl[tbl.size()-1].flg;

    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(0, 16);
      op  = (sel == 16) ? 8'($urandom) : ops[sel];
      ra  = 16'($urandom); rb = 16'($urandom);
      model(op, ra, rb, mflags, er, ef, eill, elat);
      xact(op, ra, rb, r, f, ill, lat, hs);
      chk($sformatf("rnd%0d op%h result", k, op),  32'(r),   32'(er));
      chk($sformatf("rnd%0d op%h flags", k, op),   32'(f),   32'(ef));
      chk($sformatf("rnd%0d op%h illegal", k, op), 32'(ill), 32'(eill));
      chk($sformatf("rnd%0d op%h latency", k, op), 32'(lat), 32'(elat));
      mflags = ef;
    end

    // Consumer stall: result held in DONE, new requests ignored until drained.
    model(8'h05, 16'h0005, 16'h0003, mflags, er, ef, eill, elat);
    @(negedge clock);
    bus.in_valid = 1; bus.alu_op = 8'h05; bus.a = 16'h0005; bus.b = 16'h0003;
    @(posedge clock);
    @(negedge clock);
    bus.alu_op = 8'h09; bus.a = 16'h0000; bus.b = 16'hFFFF;
    hold_r = bus.result;
    chk("stall result", 32'(hold_r), 32'(er));
    stable = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== hold_r) stable = 0;
    end
    chk("stall hold", 32'(stable), 32'd1);
    bus.in_valid = 0; bus.out_ready = 1;
    @(negedge clock);
    bus.out_ready = 0;
    chk("stall drained in_ready", 32'(bus.in_ready), 32'd1);
    chk("stall flags", 32'(bus.flags), 32'(ef));

    // Async reset in the middle of MUL aborts it and clears flags at once.
    xact(8'h05, 16'h7FFF, 16'h0001, r, f, ill, lat, hs);
    chk("pre-abort flags", 32'(f[2]), 32'd1);
    @(negedge clock);
    bus.in_valid = 1; bus.alu_op = 8'h0E; bus.a = 16'h00FF; bus.b = 16'h00FF;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 0;
    repeat (7) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort flags",     32'(bus.flags),     32'd0);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("abort in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort no result", 32'(bus.out_valid), 32'd0);
    xact(8'h05, 16'h0001, 16'h0001, r, f, ill, lat, hs);
    chk("post-abort result", 32'(r), 32'h2);
    chk("post-abort flags",  32'(f), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
